// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: moves the operand one bit per clock until the
// effective count runs out, then pulses done with the result and an illegal-op flag.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int AMT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] AMT_FULL = WIDTH'(WIDTH);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [2:0]               op_q;
    logic signed [WIDTH-1:0]  work;
    logic [CNT_W-1:0]         cnt;

    function automatic logic is_legal(input logic [2:0] o);
        return (o == OP_SHR) || (o == OP_SHRA) || (o == OP_SHL) ||
               (o == OP_ROR) || (o == OP_ROL);
    endfunction

    // Linear shifts saturate at a full-width count; rotates wrap modulo WIDTH.
    function automatic logic [CNT_W-1:0] eff_count(input logic [2:0]       o,
                                                   input logic [WIDTH-1:0] a);
        logic [CNT_W-1:0] k;
        k = '0;
        case (o)
            OP_SHR, OP_SHRA, OP_SHL: k = (a > AMT_FULL) ? CNT_FULL : a[CNT_W-1:0];
            OP_ROR, OP_ROL:          k = CNT_W'(a[AMT_W-1:0]);
            default:                 k = '0;
        endcase
        return k;
    endfunction

    function automatic logic signed [WIDTH-1:0] step(input logic [2:0]              o,
                                                     input logic signed [WIDTH-1:0] w);
        logic signed [WIDTH-1:0] s;
        s = w;
        case (o)
            OP_SHR:  s = $signed({1'b0, w[WIDTH-1:1]});
            OP_SHRA: s = w >>> 1;
            OP_SHL:  s = $signed({w[WIDTH-2:0], 1'b0});
            OP_ROR:  s = $signed({w[0], w[WIDTH-1:1]});
            OP_ROL:  s = $signed({w[WIDTH-2:0], w[WIDTH-1]});
            default: s = w;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            work   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op;
                        work  <= $signed(data_in);
                        cnt   <= eff_count(op, amount);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= step(op_q, work);
                        cnt  <= cnt - CNT_ONE;
                    end else begin
                        result <= work;
                        err    <= ~is_legal(op_q);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here; next acceptance is in IDLE
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed requests push expected
// result/err/done-cycle; a negedge monitor pops and compares on every done.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] data_in = '0;
    logic [31:0] amount = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dones_seen = 0;
    int dones_expected = 0;

    typedef struct {
        logic [31:0] res;
        logic        er;
        int          at;
    } exp_t;
    exp_t q[$];

    shift_sequencer #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            dones_seen++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h want no done (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("err", {31'b0, err}, {31'b0, e.er});
                check("done_cycle", cyc, e.at);
            end
        end
    end

    // Called right after a negedge; start is sampled on the following posedge.
    // lat is the spec latency (k+2) counted from the cycle that ends with acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [31:0] a,
                         input logic [31:0] er, input logic ee, input int lat, input bit push);
        op = o;
        data_in = d;
        amount = a;
        start = 1'b1;
        if (push) begin
            q.push_back('{er, ee, cyc + lat});
            dones_expected++;
        end
        @(negedge clock);
        start = 1'b0;
        op = 3'($urandom);
        data_in = $urandom;
        amount = $urandom;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending want 0 pending", q.size());
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_result", result, 32'd0);

        // First start accepted on the very first edge with reset low.
        reset = 1'b0;
        issue(3'b000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 6, 1);
        drain(60);
        issue(3'b001, 32'h8000_0010, 32'd40, 32'hFFFF_FFFF, 1'b0, 34, 1);
        drain(60);
        issue(3'b100, 32'h8000_0001, 32'd33, 32'h0000_0003, 1'b0, 3, 1);
        drain(60);
        issue(3'b011, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1);
        drain(60);
        issue(3'b110, 32'h1234_ABCD, 32'd7, 32'h1234_ABCD, 1'b1, 2, 1);
        drain(60);
        issue(3'b001, 32'h4000_0000, 32'd2, 32'h1000_0000, 1'b0, 4, 1);
        drain(60);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34, 1);
        drain(60);
        issue(3'b000, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 1'b0, 34, 1);
        drain(60);
        issue(3'b100, 32'h0000_0002, 32'd31, 32'h0000_0001, 1'b0, 33, 1);
        drain(60);

        // Starts mid-SHIFT and in the DONE cycle are ignored.
        issue(3'b010, 32'h0000_0001, 32'd3, 32'h0000_0008, 1'b0, 5, 1);
        op = 3'b000;
        data_in = 32'h0000_FFFF;
        amount = 32'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (done === 1'b1) break;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("hold_result_idle", result, 32'h0000_0008);
        check("idle_after_done", {31'b0, busy}, 32'd0);
        // Accepted one cycle after done.
        issue(3'b011, 32'h0000_0001, 32'd4, 32'h1000_0000, 1'b0, 6, 1);
        drain(60);

        // Reset mid-SHIFT aborts the operation with no done.
        issue(3'b010, 32'hF0F0_F0F0, 32'd20, 32'h0, 1'b0, 22, 0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        repeat (40) @(negedge clock);

        check("done_count", dones_seen, dones_expected);
        check("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
